// File: rtl/seg_scan_driver.sv
// Time-multiplexed NDIG-digit common-anode 7-segment driver with a double-buffered
// valid/ready write port. Optional leading-zero blanking: define SEG_LZB_EN.
module seg_scan_driver #(
    parameter int NDIG  = 8,
    parameter int DIV   = 1000,
    parameter int GAP   = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [4*NDIG-1:0]   wr_data,
    input  logic [NDIG-1:0]     wr_blank,
    output logic [NDIG-1:0]     an_n,
    output logic [6:0]          seg_n,
    output logic [2:0]          scan_idx,
    output logic                frame_done
);

    typedef enum logic {ST_ON, ST_OFF} state_t;

    localparam logic [2:0]       LAST_IDX = 3'(NDIG - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam bit               HAS_GAP  = (GAP > 0);

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [2:0]         idx, nxt_idx, inc_idx;

    logic [4*NDIG-1:0]  pend_data, act_data;
    logic [NDIG-1:0]    pend_blank, act_blank, blank_eff, onehot;
    logic               pend_vld;
    logic [3:0]         sel_nib;
    logic               sel_blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h01;  4'h1: hex7 = 7'h4F;
            4'h2: hex7 = 7'h12;  4'h3: hex7 = 7'h06;
            4'h4: hex7 = 7'h4C;  4'h5: hex7 = 7'h24;
            4'h6: hex7 = 7'h20;  4'h7: hex7 = 7'h0F;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h04;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h60;
            4'hC: hex7 = 7'h31;  4'hD: hex7 = 7'h42;
            4'hE: hex7 = 7'h30;  default: hex7 = 7'h38;
        endcase
    endfunction

    // Last cycle of the last digit's slot: final OFF cycle, or final ON cycle without a gap.
    function automatic logic is_end(input state_t s, input logic [CNT_W-1:0] c,
                                    input logic [2:0] i);
        if (HAS_GAP) is_end = (i == LAST_IDX) && (s == ST_OFF) && (c == GAP_LAST);
        else         is_end = (i == LAST_IDX) && (s == ST_ON)  && (c == DIV_LAST);
    endfunction

    assign wr_ready = ~pend_vld;
    assign scan_idx = idx;
    assign inc_idx  = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + CNT_W'(1);
        nxt_idx   = idx;
        if (state == ST_ON) begin
            if (cnt == DIV_LAST) begin
                nxt_cnt = '0;
                if (HAS_GAP) nxt_state = ST_OFF;
                else         nxt_idx   = inc_idx;
            end
        end else if (cnt == GAP_LAST) begin
            nxt_cnt   = '0;
            nxt_state = ST_ON;
            nxt_idx   = inc_idx;
        end
    end

`ifdef SEG_LZB_EN
    // Digit k>0 goes dark when it and every more-significant nibble are zero.
    for (genvar k = 0; k < NDIG; k++) begin : g_lzb
        if (k == 0) begin : g_first
            assign blank_eff[k] = act_blank[k];
        end else begin : g_rest
            assign blank_eff[k] = act_blank[k] | (act_data[4*NDIG-1:4*k] == '0);
        end
    end
`else
    assign blank_eff = act_blank;
`endif

    always_comb begin
        sel_nib   = '0;
        sel_blank = 1'b1;
        onehot    = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx == 3'(k)) begin
                sel_nib   = act_data[4*k +: 4];
                sel_blank = blank_eff[k];
                onehot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ON;
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
            an_n       <= '1;
            seg_n      <= 7'h7F;
            pend_data  <= '0;
            pend_blank <= '0;
            pend_vld   <= 1'b0;
            act_data   <= '0;
            act_blank  <= '1;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            idx        <= nxt_idx;
            // Registered so the pulse lines up with the frame-end cycle itself.
            frame_done <= is_end(nxt_state, nxt_cnt, nxt_idx);

            if (state == ST_ON && !sel_blank) begin
                an_n  <= ~onehot;
                seg_n <= hex7(sel_nib);
            end else begin
                an_n  <= '1;
                seg_n <= 7'h7F;
            end

            // Handshake and swap are exclusive: a swap needs pend_vld, a write needs ~pend_vld.
            if (wr_valid && wr_ready) begin
                pend_data  <= wr_data;
                pend_blank <= wr_blank;
                pend_vld   <= 1'b1;
            end else if (frame_done && pend_vld) begin
                act_data   <= pend_data;
                act_blank  <= pend_blank;
                pend_vld   <= 1'b0;
            end
        end
    end

endmodule
